// File: rtl/pal_cfg_loader_if.sv
// Configuration-stream and fabric-output bundle for pal_cfg_loader.
// The master side drives the stream; the loader sits on the slave side.
interface pal_cfg_loader_if #(
    parameter int LEN   = 64,
    parameter int LANES = 1
);
    logic             cfg_start;
    logic [LANES-1:0] cfg_in;
    logic             cfg_valid;
    logic             commit;
    logic             en;
    logic [LEN-1:0]   ff_chain;
    logic [LANES-1:0] cfg_out;
    logic             busy;
    logic             loaded;
    logic             err;

    modport master (
        output cfg_start, cfg_in, cfg_valid, commit, en,
        input  ff_chain, cfg_out, busy, loaded, err
    );

    modport slave (
        input  cfg_start, cfg_in, cfg_valid, commit, en,
        output ff_chain, cfg_out, busy, loaded, err
    );
endinterface

// File: rtl/pal_cfg_loader.sv
// PAL configuration store: serial load into a shadow register, explicit commit
// into the active register that drives the fabric, with readback and error flag.
module pal_cfg_loader #(
    parameter int LEN   = 64,
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               res,
    pal_cfg_loader_if.slave    cfg
);
    localparam int DEPTH = LEN / LANES;
    localparam int CNT_W = $clog2(DEPTH + 1);

    generate
        if ((LEN % LANES) != 0) begin : g_bad_lanes
            $error("pal_cfg_loader: LEN must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LEN-1:0]     shadow_q, shadow_d;
    logic [LEN-1:0]     active_q, active_d;
    logic               err_q, err_d;
    logic [LEN-1:0]     shadow_shift;

    // New beat enters the low slot; older beats move toward the MSB.
    generate
        if (LANES == LEN) begin : g_full_width
            assign shadow_shift = cfg.cfg_in;
        end else begin : g_shift
            assign shadow_shift = {shadow_q[LEN-LANES-1:0], cfg.cfg_in};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = err_q;

        if (cfg.commit) begin
            if (state_q == FULL) begin
                active_d = shadow_q;
                state_d  = IDLE;
            end else begin
                err_d = 1'b1;
            end
        end

        if (cfg.cfg_valid) begin
            if (state_q == LOAD) begin
                shadow_d = shadow_shift;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(DEPTH - 1)) begin
                    state_d = FULL;
                end
            end else if (state_q == FULL) begin
                err_d = 1'b1;
            end
        end

        // A start wins over any beat or error raised in the same cycle; a
        // simultaneous commit from FULL has already captured the old shadow.
        if (cfg.cfg_start) begin
            state_d  = LOAD;
            count_d  = '0;
            shadow_d = '0;
            err_d    = 1'b0;
        end
    end

    assign cfg.ff_chain = cfg.en ? active_q : '0;
    assign cfg.cfg_out  = shadow_q[LEN-1 -: LANES];
    assign cfg.busy     = (state_q == LOAD);
    assign cfg.loaded   = (state_q == FULL);
    assign cfg.err      = err_q;
endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: an 8x1 instance and a 16x4 instance
// driven through linear steps with hand-computed expectations.
module tb_pal_cfg_loader;
    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_asserts = 0;
    int   n_fails   = 0;

    always #5 clk = ~clk;

    pal_cfg_loader_if #(.LEN(8),  .LANES(1)) ia ();
    pal_cfg_loader_if #(.LEN(16), .LANES(4)) ib ();

    pal_cfg_loader #(.LEN(8),  .LANES(1)) dut_a (.clk(clk), .res(res), .cfg(ia));
    pal_cfg_loader #(.LEN(16), .LANES(4)) dut_b (.clk(clk), .res(res), .cfg(ib));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_beat(input logic b);
        ia.cfg_valid = 1'b1;
        ia.cfg_in    = b;
        step();
        ia.cfg_valid = 1'b0;
        ia.cfg_in    = 1'b0;
    endtask

    task automatic a_load(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) a_beat(v[i]);
    endtask

    task automatic a_start();
        ia.cfg_start = 1'b1;
        step();
        ia.cfg_start = 1'b0;
    endtask

    task automatic a_commit();
        ia.commit = 1'b1;
        step();
        ia.commit = 1'b0;
    endtask

    task automatic b_beat(input logic [3:0] v);
        ib.cfg_valid = 1'b1;
        ib.cfg_in    = v;
        step();
        ib.cfg_valid = 1'b0;
        ib.cfg_in    = 4'h0;
    endtask

    initial begin
        ia.cfg_start = 1'b0; ia.cfg_in = 1'b0; ia.cfg_valid = 1'b0; ia.commit = 1'b0; ia.en = 1'b1;
        ib.cfg_start = 1'b0; ib.cfg_in = 4'h0; ib.cfg_valid = 1'b0; ib.commit = 1'b0; ib.en = 1'b1;

        // Reset state
        res = 1'b1;
        step();
        res = 1'b0;
        chk("rst_ff_chain", 64'(ia.ff_chain), 64'h0);
        chk("rst_cfg_out",  64'(ia.cfg_out),  64'h0);
        chk("rst_busy",     64'(ia.busy),     64'h0);
        chk("rst_loaded",   64'(ia.loaded),   64'h0);
        chk("rst_err",      64'(ia.err),      64'h0);
        chk("rst_b_ff",     64'(ib.ff_chain), 64'h0);

        // 8x1 basic load of 1,0,1,1,0,0,1,0
        a_start();
        chk("a_busy_start", 64'(ia.busy), 64'h1);
        for (int i = 0; i < 7; i++) a_beat(i inside {0, 2, 3, 6});
        chk("a_loaded_7",   64'(ia.loaded), 64'h0);
        a_beat(1'b0);
        chk("a_loaded_8",   64'(ia.loaded), 64'h1);
        chk("a_busy_8",     64'(ia.busy),   64'h0);
        chk("a_cfg_out_8",  64'(ia.cfg_out), 64'h1);
        chk("a_ff_precommit", 64'(ia.ff_chain), 64'h0);
        a_commit();
        chk("a_ff_commit",  64'(ia.ff_chain), 64'hB2);
        chk("a_err_commit", 64'(ia.err),      64'h0);
        chk("a_loaded_idle", 64'(ia.loaded),  64'h0);

        // 16x4 load, en gating
        ib.cfg_start = 1'b1; step(); ib.cfg_start = 1'b0;
        b_beat(4'hA); b_beat(4'h5); b_beat(4'h3);
        chk("b_loaded_3",   64'(ib.loaded), 64'h0);
        b_beat(4'hC);
        chk("b_loaded_4",   64'(ib.loaded),  64'h1);
        chk("b_cfg_out",    64'(ib.cfg_out), 64'hA);
        ib.commit = 1'b1; step(); ib.commit = 1'b0;
        chk("b_ff_commit",  64'(ib.ff_chain), 64'hA53C);
        ib.en = 1'b0; #1;
        chk("b_ff_en0",     64'(ib.ff_chain), 64'h0);
        step();
        ib.en = 1'b1; #1;
        chk("b_ff_en1",     64'(ib.ff_chain), 64'hA53C);
        ib.commit = 1'b1; step(); ib.commit = 1'b0;
        chk("b_idle_commit_err", 64'(ib.err),      64'h1);
        chk("b_idle_commit_ff",  64'(ib.ff_chain), 64'hA53C);

        // Shadow isolation then reset mid-load
        a_start();
        for (int i = 0; i < 4; i++) a_beat(1'b1);
        chk("a_iso_ff",     64'(ia.ff_chain), 64'hB2);
        chk("a_iso_cfg_out", 64'(ia.cfg_out), 64'h0);
        res = 1'b1; step(); res = 1'b0;
        chk("a_rst_ff",     64'(ia.ff_chain), 64'h0);
        chk("a_rst_busy",   64'(ia.busy),     64'h0);
        chk("a_rst_loaded", 64'(ia.loaded),   64'h0);
        chk("a_rst_cfg_out", 64'(ia.cfg_out), 64'h0);

        // Premature commit, then finish the load
        a_start();
        a_beat(1'b1); a_beat(1'b0); a_beat(1'b1);
        a_commit();
        chk("a_prem_err",   64'(ia.err),      64'h1);
        chk("a_prem_busy",  64'(ia.busy),     64'h1);
        chk("a_prem_ff",    64'(ia.ff_chain), 64'h0);
        a_beat(1'b1); a_beat(1'b0); a_beat(1'b0); a_beat(1'b1);
        chk("a_prem_loaded_7", 64'(ia.loaded), 64'h0);
        a_beat(1'b0);
        chk("a_prem_loaded_8", 64'(ia.loaded), 64'h1);
        chk("a_prem_err_sticky", 64'(ia.err), 64'h1);

        // Clean load, overrun, commit proves the shadow held
        a_start();
        chk("a_start_err_clr", 64'(ia.err), 64'h0);
        a_load(8'hB2);
        chk("a_clean_err",  64'(ia.err),    64'h0);
        a_beat(1'b0);
        chk("a_ovr_err",    64'(ia.err),     64'h1);
        chk("a_ovr_cfg_out", 64'(ia.cfg_out), 64'h1);
        chk("a_ovr_loaded", 64'(ia.loaded),  64'h1);
        res = 1'b0;
        a_commit();
        chk("a_ovr_commit_ff", 64'(ia.ff_chain), 64'hB2);
        a_start();
        chk("a_ovr_start_err",  64'(ia.err),     64'h0);
        chk("a_ovr_start_busy", 64'(ia.busy),    64'h1);
        chk("a_ovr_start_out",  64'(ia.cfg_out), 64'h0);

        // Priority: start over valid in LOAD
        a_beat(1'b1); a_beat(1'b1);
        ia.cfg_start = 1'b1; ia.cfg_valid = 1'b1; ia.cfg_in = 1'b1;
        step();
        ia.cfg_start = 1'b0; ia.cfg_valid = 1'b0; ia.cfg_in = 1'b0;
        chk("a_pri_busy",   64'(ia.busy),    64'h1);
        chk("a_pri_cfg_out", 64'(ia.cfg_out), 64'h0);
        for (int i = 0; i < 7; i++) a_beat(1'b1);
        chk("a_pri_loaded_7", 64'(ia.loaded), 64'h0);
        a_beat(1'b1);
        chk("a_pri_loaded_8", 64'(ia.loaded), 64'h1);

        // Priority: commit with start in FULL
        ia.commit = 1'b1; ia.cfg_start = 1'b1;
        step();
        ia.commit = 1'b0; ia.cfg_start = 1'b0;
        chk("a_cs_ff",      64'(ia.ff_chain), 64'hFF);
        chk("a_cs_busy",    64'(ia.busy),     64'h1);
        chk("a_cs_loaded",  64'(ia.loaded),   64'h0);
        chk("a_cs_cfg_out", 64'(ia.cfg_out),  64'h0);
        ia.en = 1'b0; #1;
        chk("a_en0_ff",     64'(ia.ff_chain), 64'h0);
        ia.en = 1'b1; #1;
        chk("a_en1_ff",     64'(ia.ff_chain), 64'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
